// File: rtl/xy2_100_pkg.sv
// XY2-100 shared definitions: frame geometry, default control field, frame builder.
package xy2_100_pkg;

  localparam int unsigned XY2_FRAME_BITS   = 20;
  localparam int unsigned XY2_SYNC_LOW_BIT = 19;
  localparam logic [2:0]  XY2_CTRL_DEFAULT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } xy2_tx_state_e;

  // 20-bit frame {ctrl, word, parity}; parity makes the whole frame even.
  function automatic logic [XY2_FRAME_BITS-1:0] xy2_frame(input logic [2:0]  ctrl,
                                                          input logic [15:0] word);
    return {ctrl, word, ^{ctrl, word}};
  endfunction

endpackage

// File: rtl/xy2_100_tx_if.sv
// Host-side bus of the XY2-100 transmitter: data handshake, status and serial lines.
interface xy2_100_tx_if;
  logic        enable;
  logic [15:0] x_data;
  logic [15:0] y_data;
  logic        data_valid;
  logic        data_ready;
  logic        frame_start;
  logic        busy;
  logic        xy_clk;
  logic        xy_sync;
  logic        xy_x;
  logic        xy_y;

  modport master (
    output enable, x_data, y_data, data_valid,
    input  data_ready, frame_start, busy, xy_clk, xy_sync, xy_x, xy_y
  );

  modport slave (
    input  enable, x_data, y_data, data_valid,
    output data_ready, frame_start, busy, xy_clk, xy_sync, xy_x, xy_y
  );
endinterface

// File: rtl/xy2_100_tx_frame_shifter.sv
// Per-axis frame shift register; MSB is the bit currently on the wire.
module xy2_frame_shifter #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sr;

  // Clear wins over load, load wins over shift.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {r_sr[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[W-1];

endmodule

// File: rtl/xy2_100_tx.sv
// XY2-100 transmitter: holding buffer, timing FSM and two frame shifters (X/Y).
module xy2_100_tx
  import xy2_100_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 5,
  parameter logic [2:0]  CTRL_BITS = XY2_CTRL_DEFAULT
) (
  input  logic         clk_ref,
  input  logic         sys_rst,
  xy2_100_tx_if.slave  bus
);

  localparam int unsigned    PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [4:0]     BIT_LAST = 5'(XY2_SYNC_LOW_BIT);

  xy2_tx_state_e r_state;
  logic [PW-1:0] r_phase;
  logic          r_half;
  logic [4:0]    r_bit;
  logic          r_xy_clk;
  logic          r_xy_sync;
  logic          r_frame_start;
  logic          r_busy;
  logic          r_buf_full;
  logic [15:0]   r_buf_x, r_buf_y;
  logic [15:0]   r_last_x, r_last_y;

  logic          w_accept;
  logic          w_load;
  logic          w_bit_end;
  logic          w_frame_end;
  logic          w_shift;
  logic          w_clear;
  logic [15:0]   w_word_x, w_word_y;
  logic [XY2_FRAME_BITS-1:0] w_frame_x, w_frame_y;
  logic          w_x_msb, w_y_msb;

  assign w_accept    = bus.data_valid && !r_buf_full;
  assign w_load      = (r_state == ST_LOAD);
  assign w_bit_end   = (r_state == ST_RUN) && (r_phase == PH_LAST) && r_half;
  assign w_frame_end = w_bit_end && (r_bit == BIT_LAST);
  // Bit 19 is held through LOAD so data only ever moves with the xy_clk rise.
  assign w_shift     = w_bit_end && !w_frame_end;
  assign w_clear     = w_frame_end && !bus.enable;

  assign w_word_x  = r_buf_full ? r_buf_x : r_last_x;
  assign w_word_y  = r_buf_full ? r_buf_y : r_last_y;
  assign w_frame_x = xy2_frame(CTRL_BITS, w_word_x);
  assign w_frame_y = xy2_frame(CTRL_BITS, w_word_y);

  // Holding buffer and last-sent words; LOAD consumes before any same-cycle accept.
  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      r_buf_full <= 1'b0;
      r_buf_x    <= '0;
      r_buf_y    <= '0;
      r_last_x   <= '0;
      r_last_y   <= '0;
    end else if (w_load && r_buf_full) begin
      r_last_x   <= r_buf_x;
      r_last_y   <= r_buf_y;
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_x    <= bus.x_data;
      r_buf_y    <= bus.y_data;
      r_buf_full <= 1'b1;
    end
  end

  // Timing FSM: phase/half/bit counters and registered xy_clk, xy_sync, status.
  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_half        <= 1'b0;
      r_bit         <= '0;
      r_xy_clk      <= 1'b0;
      r_xy_sync     <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_frame_start <= 1'b0;
          r_busy        <= 1'b0;
          r_xy_clk      <= 1'b0;
          r_xy_sync     <= 1'b0;
          if (bus.enable) begin
            r_state       <= ST_LOAD;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_frame_start <= 1'b0;
          r_state       <= ST_RUN;
          r_phase       <= '0;
          r_half        <= 1'b0;
          r_bit         <= '0;
          r_xy_clk      <= 1'b1;
          r_xy_sync     <= 1'b1;
        end
        ST_RUN: begin
          if (r_phase == PH_LAST) begin
            r_phase <= '0;
            if (!r_half) begin
              r_half   <= 1'b1;
              r_xy_clk <= 1'b0;
            end else if (r_bit == BIT_LAST) begin
              if (bus.enable) begin
                r_state       <= ST_LOAD;
                r_frame_start <= 1'b1;
              end else begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_xy_sync <= 1'b0;
              end
            end else begin
              r_half    <= 1'b0;
              r_xy_clk  <= 1'b1;
              r_bit     <= r_bit + 5'd1;
              r_xy_sync <= ((r_bit + 5'd1) != BIT_LAST);
            end
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  xy2_frame_shifter #(.W(XY2_FRAME_BITS)) u_shift_x (
    .clk     (clk_ref),
    .rst     (sys_rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (w_frame_x),
    .o_msb   (w_x_msb)
  );

  xy2_frame_shifter #(.W(XY2_FRAME_BITS)) u_shift_y (
    .clk     (clk_ref),
    .rst     (sys_rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (w_frame_y),
    .o_msb   (w_y_msb)
  );

  assign bus.data_ready  = !r_buf_full;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = r_busy;
  assign bus.xy_clk      = r_xy_clk;
  assign bus.xy_sync     = r_xy_sync;
  assign bus.xy_x        = w_x_msb;
  assign bus.xy_y        = w_y_msb;

endmodule

// File: tb/tb_xy2_100_tx.sv
// Bench for xy2_100_tx: wire-level receiver plus a buffer/frame reference model.
module tb_xy2_100_tx;

  logic clk_ref = 1'b0;
  logic sys_rst;

  xy2_100_tx_if bus ();

  xy2_100_tx #(.CLK_DIV(5), .CTRL_BITS(3'b001)) dut (
    .clk_ref (clk_ref),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk_ref = ~clk_ref;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Frame from first principles: ctrl 001, word MSB first, parity = popcount parity.
  function automatic logic [19:0] ref_frame(input logic [15:0] w);
    int unsigned ones;
    ones = 1;
    for (int unsigned i = 0; i < 16; i++) ones += w[i];
    return {3'b001, w, 1'(ones % 2)};
  endfunction

  int cyc = 0;
  always @(posedge clk_ref) cyc++;

  // Reference model and receiver state
  logic        m_full = 1'b0;
  logic [15:0] m_buf_x = '0, m_buf_y = '0, m_last_x = '0, m_last_y = '0;
  logic [39:0] exp_q[$];
  logic [19:0] rx_x = '0, rx_y = '0, rx_last_x = '0, rx_last_y = '0;
  int          rx_cnt = 0;
  int          frames_rx = 0;
  logic        p_clk = 1'b0, p_x = 1'b0, p_y = 1'b0, p_sync = 1'b0;
  int          t_rise = 0, t_fs = 0;
  logic        fs_valid = 1'b0;
  int          v_ready = 0, v_edge = 0, v_clk = 0;

  always @(negedge clk_ref) begin
    logic        rise, fall, ready_now;
    logic [15:0] wx, wy;
    logic [39:0] e;
    if (sys_rst) begin
      m_full = 1'b0; m_buf_x = '0; m_buf_y = '0; m_last_x = '0; m_last_y = '0;
      exp_q.delete();
      rx_cnt = 0; fs_valid = 1'b0;
      p_clk = 1'b0; p_x = 1'b0; p_y = 1'b0; p_sync = 1'b0;
    end else begin
      rise = bus.xy_clk && !p_clk;
      fall = !bus.xy_clk && p_clk;
      ready_now = !m_full;
      if (bus.data_ready !== ready_now) v_ready++;
      if (bus.busy && !rise && (bus.xy_x !== p_x || bus.xy_y !== p_y || bus.xy_sync !== p_sync))
        v_edge++;
      if (rise) begin
        if (rx_cnt >= 1 && rx_cnt <= 19 && (cyc - t_rise) != 10) v_clk++;
        t_rise = cyc;
      end
      if (fall) begin
        if ((cyc - t_rise) != 5) v_clk++;
        rx_x = {rx_x[18:0], bus.xy_x};
        rx_y = {rx_y[18:0], bus.xy_y};
        rx_cnt++;
        if (!bus.xy_sync) begin
          chk("rx_len", rx_cnt, 20);
          if (exp_q.size() == 0) begin
            chk("rx_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rx_x", rx_x, e[39:20]);
            chk("rx_y", rx_y, e[19:0]);
          end
          rx_last_x = rx_x;
          rx_last_y = rx_y;
          frames_rx++;
          rx_cnt = 0;
        end
      end
      if (!bus.busy) fs_valid = 1'b0;
      if (bus.frame_start) begin
        if (fs_valid) chk("fs_period", cyc - t_fs, 201);
        fs_valid = 1'b1;
        t_fs = cyc;
        wx = m_full ? m_buf_x : m_last_x;
        wy = m_full ? m_buf_y : m_last_y;
        if (m_full) begin
          m_last_x = m_buf_x; m_last_y = m_buf_y; m_full = 1'b0;
        end
        exp_q.push_back({ref_frame(wx), ref_frame(wy)});
      end
      if (bus.data_valid && ready_now) begin
        m_buf_x = bus.x_data; m_buf_y = bus.y_data; m_full = 1'b1;
      end
      p_clk = bus.xy_clk; p_x = bus.xy_x; p_y = bus.xy_y; p_sync = bus.xy_sync;
    end
  end

  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int target;
    target = frames_rx + n;
    for (int i = 0; i < n * 210 + 400; i++) begin
      if (frames_rx >= target) return;
      step();
    end
    chk(tag, 0, 1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    for (int i = 0; i < 400; i++) begin
      if (rx_cnt == n) return;
      step();
    end
    chk(tag, 0, 1);
  endtask

  task automatic write(input logic [15:0] x, input logic [15:0] y, input string tag);
    int k;
    for (k = 0; k < 400 && !bus.data_ready; k++) step();
    if (k == 400) chk(tag, 0, 1);
    bus.data_valid = 1'b1; bus.x_data = x; bus.y_data = y;
    step();
    bus.data_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clk"},   bus.xy_clk, 0);
    chk({tag, "_sync"},  bus.xy_sync, 0);
    chk({tag, "_x"},     bus.xy_x, 0);
    chk({tag, "_y"},     bus.xy_y, 0);
    chk({tag, "_ready"}, bus.data_ready, 1);
    chk({tag, "_fs"},    bus.frame_start, 0);
    chk({tag, "_busy"},  bus.busy, 0);
  endtask

  initial begin
    int f0, k;
    logic [15:0] ax;
    sys_rst = 1'b1;
    bus.enable = 1'b0; bus.data_valid = 1'b0; bus.x_data = '0; bus.y_data = '0;
    repeat (4) step();
    sys_rst = 1'b0;
    step();
    chk_reset_outputs("rst");

    // T1: no data, zero words repeated
    bus.enable = 1'b1;
    wait_frames(2, "T1_timeout");
    chk("T1_x", rx_last_x, 20'h20001);
    chk("T1_y", rx_last_y, 20'h20001);

    // T2: all-ones X, LSB-only Y
    write(16'hFFFF, 16'h0001, "T2_ready_timeout");
    wait_frames(2, "T2_timeout");
    chk("T2_x", rx_last_x, 20'h3FFFF);
    chk("T2_y", rx_last_y, 20'h20002);

    // T4: second write in the same frame must be ignored
    for (k = 0; k < 400 && !bus.frame_start; k++) step();
    if (k == 400) chk("T4_fs_timeout", 0, 1);
    repeat (3) step();
    ax = 16'hA5C3;
    write(ax, 16'h1234, "T4_ready_timeout");
    chk("T4_ready_low", bus.data_ready, 0);
    bus.data_valid = 1'b1; bus.x_data = 16'h5A5A; bus.y_data = 16'h9999;
    step();
    bus.data_valid = 1'b0;
    chk("T4_ready_still_low", bus.data_ready, 0);
    wait_frames(3, "T4_timeout");
    chk("T4_repeat_x", rx_last_x, ref_frame(ax));
    chk("T4_repeat_y", rx_last_y, ref_frame(16'h1234));

    // Random writes, bursts of 1..3 valid cycles
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 250)) step();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        bus.data_valid = 1'b1;
        bus.x_data = 16'($urandom); bus.y_data = 16'($urandom);
        step();
      end
      bus.data_valid = 1'b0;
    end
    wait_frames(2, "rand_timeout");

    // T5: enable dropped at bit 7, frame still completes
    wait_rx(7, "T5_bit7_timeout");
    f0 = frames_rx;
    bus.enable = 1'b0;
    for (k = 0; k < 400 && bus.busy; k++) step();
    if (k == 400) chk("T5_idle_timeout", 0, 1);
    step();
    chk("T5_frames", frames_rx - f0, 1);
    chk("T5_busy", bus.busy, 0);
    chk("T5_clk", bus.xy_clk, 0);
    chk("T5_sync", bus.xy_sync, 0);
    chk("T5_x", bus.xy_x, 0);
    chk("T5_y", bus.xy_y, 0);

    // T6: reset at bit 12 aborts immediately
    bus.enable = 1'b1;
    wait_rx(12, "T6_bit12_timeout");
    sys_rst = 1'b1;
    step();
    chk_reset_outputs("T6");
    sys_rst = 1'b0;
    step();
    wait_frames(1, "T6_timeout");
    chk("T6_clean_x", rx_last_x, 20'h20001);
    chk("T6_clean_y", rx_last_y, 20'h20001);

    chk("ready_track", v_ready, 0);
    chk("data_on_rise_only", v_edge, 0);
    chk("xy_clk_timing", v_clk, 0);
    chk("frames_seen", (frames_rx > 10) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
